// File: rtl/serial_add_scheduler.sv
// ---------------------------------------------------------------------------
// serial_add_scheduler
//   Bit-serial adder shared by two requesters. While idle, a round-robin
//   arbiter picks a requester. Its operands are loaded into shift registers
//   and added LSB first, one bit per clock over WIDTH clocks. The result is
//   then presented for one cycle together with a done pulse to the requester
//   that was served.
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset
//   req0/a0/b0   : requester 0 request (level) and operands
//   req1/a1/b1   : requester 1 request (level) and operands
//   busy         : add in progress (SHIFT or DONE)
//   gnt          : id of the requester being served (valid while busy)
//   done0/done1  : one-cycle completion pulse to the served requester
//   sum/cout     : result of the most recent completed add
// ---------------------------------------------------------------------------
module serial_add_scheduler #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             busy,
    output logic             gnt,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Full-adder sum bit
    function automatic logic fa_sum(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    // Full-adder carry (majority of three)
    function automatic logic fa_carry(input logic x, input logic y, input logic c);
        return (x & y) | (x & c) | (y & c);
    endfunction

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              c_q, c_d;
    logic              cout_q, cout_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              gnt_q, gnt_d;
    logic              last_q, last_d;
    logic              pick_s;
    logic              bit_s;
    logic              carry_s;

    // On a tie the requester not served last wins; otherwise whoever asks
    assign pick_s  = (req0 & req1) ? ~last_q : req1;
    assign bit_s   = fa_sum(a_q[0], b_q[0], c_q);
    assign carry_s = fa_carry(a_q[0], b_q[0], c_q);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            acc_q   <= {WIDTH{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req0 | req1) begin
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: load on accept, shift one bit per SHIFT cycle
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        sum_d  = sum_q;
        c_d    = c_q;
        cout_d = cout_q;
        cnt_d  = cnt_q;
        gnt_d  = gnt_q;
        last_d = last_q;
        case (state_q)
            S_IDLE: begin
                if (req0 | req1) begin
                    a_d    = pick_s ? a1 : a0;
                    b_d    = pick_s ? b1 : b0;
                    c_d    = 1'b0;
                    cnt_d  = {CW{1'b0}};
                    gnt_d  = pick_s;
                    last_d = pick_s;
                end else begin
                    a_d = a_q;
                end
            end
            S_SHIFT: begin
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                acc_d = {bit_s, acc_q[WIDTH-1:1]};
                c_d   = carry_s;
                cnt_d = cnt_q + CW'(1);
                // Publish only the completed result so partial sums never show
                if (cnt_q == CNT_LAST) begin
                    sum_d  = {bit_s, acc_q[WIDTH-1:1]};
                    cout_d = carry_s;
                end else begin
                    sum_d  = sum_q;
                end
            end
            S_DONE:  a_d = a_q;
            default: a_d = a_q;
        endcase
    end

    // Outputs decoded from registered state
    always_comb begin
        busy  = 1'b0;
        done0 = 1'b0;
        done1 = 1'b0;
        case (state_q)
            S_IDLE:  busy = 1'b0;
            S_SHIFT: busy = 1'b1;
            S_DONE: begin
                busy  = 1'b1;
                done0 = ~gnt_q;
                done1 = gnt_q;
            end
            default: busy = 1'b0;
        endcase
    end

    assign gnt  = gnt_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
